// File: rtl/sdram_arbit.sv
// rtl/sdram_arbit.sv - SDRAM command arbiter between init, refresh, write and read clients
//
// Ports:
//   sclk, s_rst_n                      clock, asynchronous active-low reset
//   init_cmd/init_addr/flag_init_end   init sequencer command, address and done level
//   ref_req/ref_en/flag_ref_end        refresh request, grant and done
//   aref_cmd/aref_addr                 refresh command and address
//   wr_req/wr_en/flag_wr_end           write request, grant and done
//   wr_cmd/wr_addr/wr_bank             write command, address and bank
//   rd_req/rd_en/flag_rd_end           read request, grant and done
//   rd_cmd/rd_addr/rd_bank             read command, address and bank
//   sdram_*                            SDRAM command, bank and address pins
//   arb_state                          one-hot state register (debug)
module sdram_arbit #(
  parameter logic [3:0] NOP_CMD = 4'b0111
) (
  input  logic        sclk,
  input  logic        s_rst_n,
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic        flag_init_end,
  input  logic        ref_req,
  output logic        ref_en,
  input  logic        flag_ref_end,
  input  logic [3:0]  aref_cmd,
  input  logic [12:0] aref_addr,
  input  logic        wr_req,
  output logic        wr_en,
  input  logic        flag_wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [12:0] wr_addr,
  input  logic [1:0]  wr_bank,
  input  logic        rd_req,
  output logic        rd_en,
  input  logic        flag_rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [12:0] rd_addr,
  input  logic [1:0]  rd_bank,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_bank,
  output logic [12:0] sdram_addr,
  output logic [4:0]  arb_state
);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    ARBIT = 5'b00010,
    AREF  = 5'b00100,
    WRITE = 5'b01000,
    READ  = 5'b10000
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cmd;

  // Every client returns to ARBIT when done, so a fresh arbitration cycle
  // always separates two grants and an active client is never preempted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flag_init_end) state_d = ARBIT;
      ARBIT: begin
        if (ref_req)     state_d = AREF;
        else if (wr_req) state_d = WRITE;
        else if (rd_req) state_d = READ;
      end
      AREF:    if (flag_ref_end) state_d = ARBIT;
      WRITE:   if (flag_wr_end)  state_d = ARBIT;
      READ:    if (flag_rd_end)  state_d = ARBIT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  assign arb_state = state_q;

  // Grants decode the state register directly so that a reset drops them
  // without waiting for a clock edge.
  assign ref_en = (state_q == AREF);
  assign wr_en  = (state_q == WRITE);
  assign rd_en  = (state_q == READ);

  always_comb begin
    cmd        = NOP_CMD;
    sdram_addr = 13'd0;
    sdram_bank = 2'b00;
    case (state_q)
      IDLE: begin
        cmd        = init_cmd;
        sdram_addr = init_addr;
      end
      AREF: begin
        cmd        = aref_cmd;
        sdram_addr = aref_addr;
      end
      WRITE: begin
        cmd        = wr_cmd;
        sdram_addr = wr_addr;
        sdram_bank = wr_bank;
      end
      READ: begin
        cmd        = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: begin
        cmd        = NOP_CMD;
        sdram_addr = 13'd0;
        sdram_bank = 2'b00;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke = 1'b1;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb/tb_sdram_arbit.sv - scoreboard testbench for sdram_arbit
module tb_sdram_arbit;

  logic        sclk = 1'b0;
  logic        s_rst_n;
  logic [3:0]  init_cmd;
  logic [12:0] init_addr;
  logic        flag_init_end;
  logic        ref_req, ref_en, flag_ref_end;
  logic [3:0]  aref_cmd;
  logic [12:0] aref_addr;
  logic        wr_req, wr_en, flag_wr_end;
  logic [3:0]  wr_cmd;
  logic [12:0] wr_addr;
  logic [1:0]  wr_bank;
  logic        rd_req, rd_en, flag_rd_end;
  logic [3:0]  rd_cmd;
  logic [12:0] rd_addr;
  logic [1:0]  rd_bank;
  logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_bank;
  logic [12:0] sdram_addr;
  logic [4:0]  arb_state;

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_ARBIT = 5'b00010;
  localparam logic [4:0] S_AREF  = 5'b00100;
  localparam logic [4:0] S_WRITE = 5'b01000;
  localparam logic [4:0] S_READ  = 5'b10000;
  // grant vectors ordered {ref_en, wr_en, rd_en}
  localparam logic [2:0] G_NONE = 3'b000;
  localparam logic [2:0] G_REF  = 3'b100;
  localparam logic [2:0] G_WR   = 3'b010;
  localparam logic [2:0] G_RD   = 3'b001;

  sdram_arbit #(.NOP_CMD(4'b0111)) dut (
    .sclk(sclk), .s_rst_n(s_rst_n),
    .init_cmd(init_cmd), .init_addr(init_addr), .flag_init_end(flag_init_end),
    .ref_req(ref_req), .ref_en(ref_en), .flag_ref_end(flag_ref_end),
    .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .wr_req(wr_req), .wr_en(wr_en), .flag_wr_end(flag_wr_end),
    .wr_cmd(wr_cmd), .wr_addr(wr_addr), .wr_bank(wr_bank),
    .rd_req(rd_req), .rd_en(rd_en), .flag_rd_end(flag_rd_end),
    .rd_cmd(rd_cmd), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_bank(sdram_bank), .sdram_addr(sdram_addr), .arb_state(arb_state)
  );

  always #5 sclk = ~sclk;

  int cyc = 0;
  always @(posedge sclk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    string       name;
    logic [4:0]  st;
    logic [2:0]  g;
    logic [3:0]  cmd;
    logic [1:0]  bank;
    logic [12:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Stimulus calls this after driving the cycle's inputs; the monitor compares
  // the entry at the following falling edge of the same cycle.
  task automatic chk(input string name, input logic [4:0] st, input logic [2:0] g,
                     input logic [3:0] cmd, input logic [1:0] bank, input logic [12:0] addr);
    exp_t e;
    e.cyc = cyc; e.name = name; e.st = st; e.g = g;
    e.cmd = cmd; e.bank = bank; e.addr = addr;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge sclk);
    #1;
  endtask

  // Monitor
  exp_t m;
  logic [25:0] act_v, exp_v;
  always @(negedge sclk) begin
    n_cmp++;
    if ($countones({ref_en, wr_en, rd_en}) > 1) begin
      n_bad++;
      $display("FAIL grant_excl cyc=%0d grants=%b required at most one high", cyc, {ref_en, wr_en, rd_en});
    end
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      m = exp_q.pop_front();
      n_cmp++;
      act_v = {arb_state, ref_en, wr_en, rd_en, sdram_cs_n, sdram_ras_n, sdram_cas_n,
               sdram_we_n, sdram_bank, sdram_addr, sdram_cke};
      exp_v = {m.st, m.g, m.cmd, m.bank, m.addr, 1'b1};
      if (m.cyc != cyc || act_v !== exp_v) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got st=%b g=%b cmd=%b bank=%b addr=%h cke=%b required st=%b g=%b cmd=%b bank=%b addr=%h cke=1 (for cyc %0d)",
                 m.name, cyc, arb_state, {ref_en, wr_en, rd_en},
                 {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, sdram_bank, sdram_addr, sdram_cke,
                 m.st, m.g, m.cmd, m.bank, m.addr, m.cyc);
      end
    end
  end

  initial begin
    #100000;
    n_bad++;
    $display("FAIL watchdog time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    s_rst_n = 1'b0;
    init_cmd = 4'b0010; init_addr = 13'h0400; flag_init_end = 1'b0;
    ref_req = 1'b0; flag_ref_end = 1'b0; aref_cmd = 4'b0001; aref_addr = 13'h0123;
    wr_req = 1'b0; flag_wr_end = 1'b0; wr_cmd = 4'b0100; wr_addr = 13'h0A5A; wr_bank = 2'b01;
    rd_req = 1'b0; flag_rd_end = 1'b0; rd_cmd = 4'b0101; rd_addr = 13'h1ABC; rd_bank = 2'b11;

    // reset: pins follow init sources, requests cause nothing
    step();
    ref_req = 1'b1; wr_req = 1'b1;
    chk("rst_state", S_IDLE, G_NONE, 4'b0010, 2'b00, 13'h0400);
    step();
    init_cmd = 4'b1000; init_addr = 13'h0001;
    chk("rst_follow", S_IDLE, G_NONE, 4'b1000, 2'b00, 13'h0001);
    step();
    init_cmd = 4'b0010; init_addr = 13'h0400; ref_req = 1'b0; wr_req = 1'b0;
    s_rst_n = 1'b1;
    chk("rst_release", S_IDLE, G_NONE, 4'b0010, 2'b00, 13'h0400);
    step();
    chk("idle_wait", S_IDLE, G_NONE, 4'b0010, 2'b00, 13'h0400);

    // init pass-through and exit to ARBIT
    flag_init_end = 1'b1;
    chk("init_pass", S_IDLE, G_NONE, 4'b0010, 2'b00, 13'h0400);
    step();
    flag_init_end = 1'b0;
    chk("arbit_nop", S_ARBIT, G_NONE, 4'b0111, 2'b00, 13'h0000);
    step();
    chk("init_drop", S_ARBIT, G_NONE, 4'b0111, 2'b00, 13'h0000);

    // refresh cycle
    ref_req = 1'b1;
    chk("ref_req_arbit", S_ARBIT, G_NONE, 4'b0111, 2'b00, 13'h0000);
    step();
    ref_req = 1'b0;
    chk("ref_grant", S_AREF, G_REF, 4'b0001, 2'b00, 13'h0123);
    step();
    flag_ref_end = 1'b1;
    chk("ref_hold", S_AREF, G_REF, 4'b0001, 2'b00, 13'h0123);
    step();
    flag_ref_end = 1'b0;
    chk("ref_end", S_ARBIT, G_NONE, 4'b0111, 2'b00, 13'h0000);

    // simultaneous requests
    ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    step();
    ref_req = 1'b0; flag_ref_end = 1'b1;
    chk("sim_ref", S_AREF, G_REF, 4'b0001, 2'b00, 13'h0123);
    step();
    flag_ref_end = 1'b0;
    chk("sim_gap1", S_ARBIT, G_NONE, 4'b0111, 2'b00, 13'h0000);
    step();
    wr_req = 1'b0; flag_wr_end = 1'b1;
    chk("sim_wr", S_WRITE, G_WR, 4'b0100, 2'b01, 13'h0A5A);
    step();
    flag_wr_end = 1'b0;
    chk("sim_gap2", S_ARBIT, G_NONE, 4'b0111, 2'b00, 13'h0000);
    step();
    rd_req = 1'b0; flag_rd_end = 1'b1;
    chk("sim_rd", S_READ, G_RD, 4'b0101, 2'b11, 13'h1ABC);
    step();
    flag_rd_end = 1'b0;
    chk("sim_gap3", S_ARBIT, G_NONE, 4'b0111, 2'b00, 13'h0000);

    // no preemption of a write by a refresh
    wr_req = 1'b1;
    step();
    wr_req = 1'b0; ref_req = 1'b1;
    chk("nopre_wr", S_WRITE, G_WR, 4'b0100, 2'b01, 13'h0A5A);
    step();
    chk("nopre_hold1", S_WRITE, G_WR, 4'b0100, 2'b01, 13'h0A5A);
    step();
    flag_wr_end = 1'b1;
    chk("nopre_hold2", S_WRITE, G_WR, 4'b0100, 2'b01, 13'h0A5A);
    step();
    flag_wr_end = 1'b0;
    chk("nopre_arbit", S_ARBIT, G_NONE, 4'b0111, 2'b00, 13'h0000);
    step();
    ref_req = 1'b0; flag_ref_end = 1'b1;
    chk("nopre_ref", S_AREF, G_REF, 4'b0001, 2'b00, 13'h0123);
    step();
    flag_ref_end = 1'b0;

    // a request pulse that ends before the sampling edge is lost
    wr_req = 1'b1;
    #3 wr_req = 1'b0;
    step();
    chk("drop_req", S_ARBIT, G_NONE, 4'b0111, 2'b00, 13'h0000);

    // read bank/address mux and stray end flags
    rd_req = 1'b1;
    step();
    rd_req = 1'b0; flag_wr_end = 1'b1; flag_ref_end = 1'b1;
    chk("rd_mux", S_READ, G_RD, 4'b0101, 2'b11, 13'h1ABC);
    step();
    flag_wr_end = 1'b0; flag_ref_end = 1'b0;
    chk("rd_stray", S_READ, G_RD, 4'b0101, 2'b11, 13'h1ABC);
    step();

    // asynchronous reset in the middle of a read
    s_rst_n = 1'b0;
    chk("rst_mid_rd", S_IDLE, G_NONE, 4'b0010, 2'b00, 13'h0400);
    step();
    s_rst_n = 1'b1; ref_req = 1'b1; wr_req = 1'b1;
    step();
    chk("post_rst_ign1", S_IDLE, G_NONE, 4'b0010, 2'b00, 13'h0400);
    step();
    flag_init_end = 1'b1;
    chk("post_rst_ign2", S_IDLE, G_NONE, 4'b0010, 2'b00, 13'h0400);
    step();
    chk("reinit_arbit", S_ARBIT, G_NONE, 4'b0111, 2'b00, 13'h0000);
    step();
    ref_req = 1'b0; wr_req = 1'b0;
    chk("reinit_ref", S_AREF, G_REF, 4'b0001, 2'b00, 13'h0123);
    step();
    step();

    if (exp_q.size() != 0) begin
      n_bad += exp_q.size();
      $display("FAIL scoreboard_drain left=%0d required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbit.md
SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 SHALL have parameter: NOP_CMD, 4'b0111, command driven in ARBIT state ({cs_n,ras_n,cas_n,we_n}).
REQ-002 SHALL have ports:
- sclk  in  1  clock.
- s_rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have init ports:
- init_cmd  in  4  init command.
- init_addr  in  13  init address.
- flag_init_end  in  1  init done (level).
REQ-004 SHALL have refresh ports:
- ref_req  in  1  refresh request.
- ref_en  out  1  refresh grant.
- flag_ref_end  in  1  refresh done.
- aref_cmd  in  4  refresh command.
- aref_addr  in  13  refresh address.
REQ-005 SHALL have write ports:
- wr_req  in  1  write request.
- wr_en  out  1  write grant.
- flag_wr_end  in  1  write done.
- wr_cmd  in  4  write command.
- wr_addr  in  13  write address.
- wr_bank  in  2  write bank.
REQ-006 SHALL have read ports:
- rd_req  in  1  read request.
- rd_en  out  1  read grant.
- flag_rd_end  in  1  read done.
- rd_cmd  in  4  read command.
- rd_addr  in  13  read address.
- rd_bank  in  2  read bank.
REQ-007 SHALL have SDRAM-side outputs, all 1 bit unless noted:
- sdram_cke  out  1  clock enable.
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins.
- sdram_bank  out  2  bank address.
- sdram_addr  out  13  row/column address.
- arb_state  out  5  current state, one-hot (debug).

Function
REQ-008 SHALL implement a one-hot FSM with states IDLE=00001, ARBIT=00010, AREF=00100, WRITE=01000, READ=10000; arb_state = state register.
REQ-009 IDLE SHALL go to ARBIT on the clock edge where flag_init_end=1 is sampled, and otherwise remain in IDLE.
REQ-010 ARBIT SHALL sample requests each cycle with fixed priority ref_req > wr_req > rd_req, moving to AREF, WRITE or READ respectively; with no request it SHALL remain in ARBIT.
REQ-011 AREF, WRITE and READ SHALL return to ARBIT on the edge where their own flag_ref_end, flag_wr_end or flag_rd_end =1 is sampled; end flags of other clients SHALL be ignored.
REQ-012 Grant outputs SHALL be combinational decodes of the state: ref_en=(state==AREF), wr_en=(state==WRITE), rd_en=(state==READ); at most one grant SHALL be high in any cycle.
REQ-013 Grant latency SHALL be exactly one cycle: a request sampled in ARBIT at edge N SHALL produce its grant high from edge N onward.
REQ-014 Requests arriving while another client is granted SHALL NOT preempt it; they SHALL be evaluated in the first ARBIT cycle after the current client's end flag.
REQ-015 After any client ends, the FSM SHALL spend at least one cycle in ARBIT before the next grant.
REQ-016 A request that deasserts before it is sampled in ARBIT SHALL produce no grant.
REQ-017 The command/address mux SHALL be combinational on the state register:
- IDLE: {cs_n,ras_n,cas_n,we_n}=init_cmd, addr=init_addr, bank=2'b00.
- ARBIT: NOP_CMD, addr=13'd0, bank=2'b00.
- AREF: aref_cmd, aref_addr, bank=2'b00.
- WRITE: wr_cmd, wr_addr, wr_bank.
- READ: rd_cmd, rd_addr, rd_bank.
REQ-018 sdram_cke SHALL be constant 1.
REQ-019 A drop of flag_init_end after leaving IDLE SHALL be ignored; the FSM SHALL never return to IDLE except by reset.

Reset
REQ-020 While s_rst_n=0, state SHALL be IDLE (arb_state=00001), all grants SHALL be 0, SDRAM pins SHALL follow init_cmd/init_addr, and bank SHALL be 0.
REQ-021 Reset asserted mid-grant SHALL drop the grant immediately (asynchronously); after release the FSM SHALL wait for flag_init_end again.

Verification
REQ-022 The bench SHALL cover:
- Init pass-through: reset, init_cmd=4'b0010, init_addr=13'h0400 -> sdram pins {0,0,1,0}, addr 0x0400; flag_init_end=1 -> arb_state=00010 next edge, pins=0111.
- Refresh cycle: ref_req=1 in ARBIT -> ref_en=1 next edge; aref_cmd=0001 appears on pins; flag_ref_end pulse -> ref_en=0, ARBIT next edge.
- Simultaneous requests: ref_req=wr_req=rd_req=1 -> order AREF, WRITE, READ, with >=1 ARBIT cycle between each; never two grants high at once.
- No preemption: ref_req rises during WRITE -> wr_en held until flag_wr_end; ref_en rises one ARBIT cycle later.
- Bank/addr mux: READ with rd_bank=2'b11, rd_addr=13'h1ABC -> sdram_bank=11, sdram_addr=0x1ABC; stray flag_wr_end=1 during READ -> no state change.
- Reset during READ -> rd_en=0 immediately, arb_state=00001; requests are ignored until flag_init_end=1.
